// File: rtl/systolic_engine.sv
// Output-stationary ROWS x COLS matrix-multiply engine with input skew,
// valid/ready streaming, signed/unsigned operands and tile accumulation.
module systolic_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 16,
  parameter int SIGNED     = 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       accumulate,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] in_a_flat,
  input  logic [DATA_WIDTH*COLS-1:0] in_b_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [RW-1:0]              out_row,
  output logic [CW-1:0]              out_col,
  output logic                       out_last
);

  localparam int FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {
    IDLE, FEED, FLUSH, DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [K_WIDTH-1:0]   k_q, k_d;
  logic [K_WIDTH-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]        fl_q, fl_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 done_q, done_d;
  logic                 clr;

  logic [DATA_WIDTH-1:0] a_q   [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_q   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];

  logic [ROWS-1:0][DATA_WIDTH-1:0] a_inj, a_sk;
  logic [COLS-1:0][DATA_WIDTH-1:0] b_inj, b_sk;

  logic in_hs, out_hs, row_end, col_end;

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == FEED);
  assign out_valid = (state_q == DRAIN);
  assign done      = done_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign row_end   = (row_q == RW'(ROWS - 1));
  assign col_end   = (col_q == CW'(COLS - 1));
  assign out_last  = out_valid && row_end && col_end;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_data  = acc_q[row_q][col_q];

  // Bubbles inject zeros so the array can shift unconditionally.
  assign a_inj = in_hs ? in_a_flat : '0;
  assign b_inj = in_hs ? in_b_flat : '0;

  function automatic logic [ACC_WIDTH-1:0] mul(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0]     ax, bx;
    logic signed [2*DATA_WIDTH+1:0] p;
    ax = {(SIGNED != 0) && a[DATA_WIDTH-1], a};
    bx = {(SIGNED != 0) && b[DATA_WIDTH-1], b};
    p  = ax * bx;
    return ACC_WIDTH'(p);
  endfunction

  for (genvar i = 0; i < ROWS; i++) begin : g_ask
    if (i == 0) begin : g_d0
      assign a_sk[i] = a_inj[i];
    end else begin : g_dn
      logic [DATA_WIDTH-1:0] sk_q [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) sk_q[d] <= '0;
        end else begin
          sk_q[0] <= a_inj[i];
          for (int d = 1; d < i; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign a_sk[i] = sk_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bsk
    if (j == 0) begin : g_d0
      assign b_sk[j] = b_inj[j];
    end else begin : g_dn
      logic [DATA_WIDTH-1:0] sk_q [j];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < j; d++) sk_q[d] <= '0;
        end else begin
          sk_q[0] <= b_inj[j];
          for (int d = 1; d < j; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign b_sk[j] = sk_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        a_q[i][0] <= a_sk[i];
        for (int j = 1; j < COLS; j++) a_q[i][j] <= a_q[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_q[0][j] <= b_sk[j];
        for (int i = 1; i < ROWS; i++) b_q[i][j] <= b_q[i-1][j];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          acc_q[i][j] <= clr ? '0
                       : acc_q[i][j] + mul(a_q[i][j], b_q[i][j]);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          cnt_d   = '0;
          fl_d    = FW'(ROWS + COLS - 1);
          row_d   = '0;
          col_d   = '0;
          clr     = !accumulate;
          state_d = (k_len == '0) ? FLUSH : FEED;
        end
      end
      FEED: begin
        if (in_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == k_q - 1'b1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        fl_d = fl_q - 1'b1;
        if (fl_q == FW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs) begin
          if (row_end && col_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_systolic_engine.sv
// Directed bench for systolic_engine on a 2x2 array, with signed and
// unsigned instances sharing one stimulus stream.
module tb_systolic_engine;
  localparam int DW = 8;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int AW = 32;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          accumulate;
  logic          in_valid;
  logic          out_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;

  logic          s_busy, s_done, s_in_ready, s_valid, s_last;
  logic [AW-1:0] s_data;
  logic [0:0]    s_row, s_col;
  logic          u_busy, u_done, u_in_ready, u_valid, u_last;
  logic [AW-1:0] u_data;
  logic [0:0]    u_row, u_col;

  logic          sel_u;
  logic          busy, done, in_ready, out_valid, out_last;
  logic [AW-1:0] out_data;
  logic [0:0]    out_row, out_col;

  assign busy      = sel_u ? u_busy     : s_busy;
  assign done      = sel_u ? u_done     : s_done;
  assign in_ready  = sel_u ? u_in_ready : s_in_ready;
  assign out_valid = sel_u ? u_valid    : s_valid;
  assign out_last  = sel_u ? u_last     : s_last;
  assign out_data  = sel_u ? u_data     : s_data;
  assign out_row   = sel_u ? u_row      : s_row;
  assign out_col   = sel_u ? u_col      : s_col;

  always #5 clk = ~clk;

  systolic_engine #(
    .DATA_WIDTH(DW), .ROWS(R), .COLS(C),
    .ACC_WIDTH(AW), .K_WIDTH(KW), .SIGNED(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .accumulate(accumulate), .busy(s_busy), .done(s_done),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a_flat(in_a), .in_b_flat(in_b),
    .out_valid(s_valid), .out_ready(out_ready),
    .out_data(s_data), .out_row(s_row), .out_col(s_col),
    .out_last(s_last)
  );

  systolic_engine #(
    .DATA_WIDTH(DW), .ROWS(R), .COLS(C),
    .ACC_WIDTH(AW), .K_WIDTH(KW), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .accumulate(accumulate), .busy(u_busy), .done(u_done),
    .in_valid(in_valid), .in_ready(u_in_ready),
    .in_a_flat(in_a), .in_b_flat(in_b),
    .out_valid(u_valid), .out_ready(out_ready),
    .out_data(u_data), .out_row(u_row), .out_col(u_col),
    .out_last(u_last)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]   beat_a [4];
  logic [15:0]   beat_b [4];
  logic [AW-1:0] r_data [16];
  logic          r_row  [16];
  logic          r_col  [16];
  logic          r_last [16];
  int            n_res, first_valid, done_cyc, last_hs_cyc;
  int            acc_beats, stall_err;
  logic          busy_at_done;
  bit            to;

  logic [AW-1:0] exp_c [4];

  // Runs one operation and records what it saw; checks live in tests.
  task automatic run(input int k, input bit accm, input bit rnd,
                     input int stall_idx, input bit glitch);
    int            cyc, beat, stall_left;
    bit            held;
    logic [AW-1:0] hd;
    logic          hr, hc, hl;
    n_res = 0; first_valid = -1; done_cyc = -1; last_hs_cyc = -1;
    acc_beats = 0; stall_err = 0; to = 0; busy_at_done = 1'bx;
    beat = 0; stall_left = 5; held = 0;
    hd = '0; hr = 0; hc = 0; hl = 0;
    start = 1; k_len = KW'(k); accumulate = accm;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    start = 0; k_len = 16'hFFFF; accumulate = ~accm;
    cyc = 1;
    while (!to) begin
      if (held && (out_data !== hd || out_row !== hr ||
                   out_col !== hc || out_last !== hl))
        stall_err++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
        break;
      end
      start = glitch && (cyc == 2);
      if (beat < k) in_valid = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      else in_valid = rnd;
      if (in_valid && beat < k) begin
        in_a = beat_a[beat];
        in_b = beat_b[beat];
      end else begin
        in_a = 16'hA5C3;
        in_b = 16'h7E19;
      end
      out_ready = !(stall_idx >= 0 && n_res == stall_idx &&
                    out_valid && stall_left > 0);
      if (!out_ready) stall_left--;
      held = out_valid && !out_ready;
      hd = out_data; hr = out_row; hc = out_col; hl = out_last;
      if (in_valid && in_ready) begin
        acc_beats++;
        if (beat < k) beat++;
      end
      if (out_valid && out_ready && n_res < 16) begin
        r_data[n_res] = out_data;
        r_row[n_res]  = out_row;
        r_col[n_res]  = out_col;
        r_last[n_res] = out_last;
        last_hs_cyc = cyc;
        n_res++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) to = 1;
    end
    start = 0; in_valid = 0; out_ready = 1;
  endtask

  task automatic load_tile();
    beat_a[0] = {8'd3, 8'd1}; beat_b[0] = {8'd6, 8'd5};
    beat_a[1] = {8'd4, 8'd2}; beat_b[1] = {8'd8, 8'd7};
  endtask

  task automatic check_results(input string nm);
    n_cmp++;
    if (to !== 1'b0 || n_res !== 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results (timeout=%0b) want 4",
               nm, n_res, to);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (r_data[i] !== exp_c[i]) begin
        n_fail++;
        $display("FAIL %s_data[%0d]: got %0d want %0d",
                 nm, i, r_data[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset();
    sel_u = 0; rst = 0; start = 0; k_len = '0; accumulate = 0;
    in_valid = 0; out_ready = 1; in_a = '0; in_b = '0;
    #12;
    n_cmp++;
    if ({busy, done, in_ready, out_valid, out_last, out_row, out_col}
        !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, in_ready, out_valid, out_last,
                out_row, out_col});
    end
    n_cmp++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h want 0", out_data);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_product();
    load_tile();
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    run(2, 0, 0, -1, 0);
    check_results("prod");
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({r_row[i], r_col[i], r_last[i]} !==
          {i[1], i[0], (i == 3)}) begin
        n_fail++;
        $display("FAIL prod_order[%0d]: got row%0d col%0d last%0d",
                 i, r_row[i], r_col[i], r_last[i]);
      end
    end
    n_cmp++;
    if (first_valid !== 6) begin
      n_fail++;
      $display("FAIL latency: got %0d want 6", first_valid);
    end
    n_cmp++;
    if (done_cyc !== last_hs_cyc + 1 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_timing: done %0d last_hs %0d busy %b",
               done_cyc, last_hs_cyc, busy_at_done);
    end
  endtask

  task automatic test_back_to_back_accumulate();
    exp_c = '{32'd38, 32'd44, 32'd86, 32'd100};
    run(2, 1, 0, -1, 0);
    check_results("accum");
  endtask

  task automatic test_signedness();
    for (int b = 0; b < 3; b++) begin
      beat_a[b] = 16'hFFFF;
      beat_b[b] = 16'h7F7F;
    end
    sel_u = 0;
    for (int i = 0; i < 4; i++) exp_c[i] = 32'hFFFFFE83;
    run(3, 0, 0, -1, 0);
    check_results("signed");
    sel_u = 1;
    for (int i = 0; i < 4; i++) exp_c[i] = 32'(3 * 255 * 127);
    run(3, 0, 0, -1, 0);
    check_results("unsigned");
    sel_u = 0;
  endtask

  task automatic test_bubbles_backpressure();
    load_tile();
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    run(2, 0, 1, 1, 0);
    check_results("bubble");
    n_cmp++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d changes want 0", stall_err);
    end
    n_cmp++;
    if (acc_beats !== 2) begin
      n_fail++;
      $display("FAIL beats_accepted: got %0d want 2", acc_beats);
    end
  endtask

  task automatic test_k_zero();
    exp_c = '{32'd0, 32'd0, 32'd0, 32'd0};
    run(0, 0, 0, -1, 0);
    check_results("kzero");
    n_cmp++;
    if (done_cyc !== last_hs_cyc + 1) begin
      n_fail++;
      $display("FAIL kzero_done: got %0d want %0d",
               done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_start_ignored();
    load_tile();
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    run(2, 0, 0, -1, 1);
    check_results("glitch");
  endtask

  task automatic test_reset_mid_feed();
    load_tile();
    start = 1; k_len = 2; accumulate = 0;
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    in_a = beat_a[0]; in_b = beat_b[0];
    @(posedge clk); #1;
    rst = 0;
    #1;
    n_cmp++;
    if ({busy, done, in_ready, out_valid, out_last, out_row, out_col}
        !== 7'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_outs: got %b data %0h want all 0",
               {busy, done, in_ready, out_valid, out_last,
                out_row, out_col}, out_data);
    end
    in_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    run(2, 1, 0, -1, 0);
    check_results("midreset");
  endtask

  initial begin
    test_reset();
    test_product();
    test_back_to_back_accumulate();
    test_signedness();
    test_bubbles_backpressure();
    test_k_zero();
    test_start_ignored();
    test_reset_mid_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
